// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch prediction unit: predictor mode, BTB entry layout,
// the resolved-branch update bundle carried down the pipe, and PHT write operations.
package bp_types;

  typedef enum logic {
    BP_BIMODAL = 1'b0,
    BP_GSHARE  = 1'b1
  } bp_mode_e;

  typedef enum logic [1:0] {
    BP_CTR_INC    = 2'd0,
    BP_CTR_DEC    = 2'd1,
    BP_CTR_SET_WT = 2'd2
  } bp_ctr_op_e;

  // Tag is kept at full word width; bits above the real tag are always zero.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    logic        jump;
  } bp_btb_entry_t;

  typedef struct packed {
    logic        valid;
    logic        stall;
    logic [31:0] pc;
    logic        is_jump;
    logic        taken;
    logic [31:0] target;
    logic        pred_taken;
    logic [31:0] pred_target;
  } bp_upd_t;

  function automatic logic [31:0] bp_tag(input logic [31:0] pc, input int unsigned idx_bits);
    return pc >> (idx_bits + 2);
  endfunction

  function automatic logic [31:0] bp_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_ctr_table.sv
// Pattern history table: array of saturating counters with a combinational read
// port and a single read-modify-write port (increment, decrement or set weakly-taken).
module bp_sat_ctr_table
  import bp_types::*;
#(
  parameter int unsigned ENTRIES = 256,
  parameter int unsigned WIDTH   = 2,
  localparam int unsigned IW     = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IW-1:0]    i_rd_idx,
  output logic [WIDTH-1:0] o_rd_ctr,
  input  logic             i_wr_en,
  input  logic [IW-1:0]    i_wr_idx,
  input  bp_ctr_op_e       i_wr_op
);

  localparam logic [WIDTH-1:0] P_WEAK_NT = WIDTH'((1 << (WIDTH - 1)) - 1);
  localparam logic [WIDTH-1:0] P_WEAK_T  = WIDTH'(1 << (WIDTH - 1));
  localparam logic [WIDTH-1:0] P_MAX     = '1;

  logic [WIDTH-1:0] r_ctr [ENTRIES];
  logic [WIDTH-1:0] w_cur;
  logic [WIDTH-1:0] w_nxt;

  assign o_rd_ctr = r_ctr[i_rd_idx];
  assign w_cur    = r_ctr[i_wr_idx];

  always_comb begin
    w_nxt = w_cur;
    case (i_wr_op)
      BP_CTR_INC:    w_nxt = (w_cur == P_MAX) ? w_cur : w_cur + WIDTH'(1);
      BP_CTR_DEC:    w_nxt = (w_cur == '0)    ? w_cur : w_cur - WIDTH'(1);
      BP_CTR_SET_WT: w_nxt = P_WEAK_T;
      default:       w_nxt = w_cur;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= P_WEAK_NT;
      end
    end else if (i_wr_en) begin
      r_ctr[i_wr_idx] <= w_nxt;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Branch prediction unit: direct-mapped BTB plus bimodal/gshare PHT, zero-latency
// lookup for IF, non-speculative training from EX, saturating perf counters.
module branch_predictor
  import bp_types::*;
#(
  parameter int unsigned BTB_ENTRIES = 32,
  parameter int unsigned PHT_ENTRIES = 256,
  parameter int unsigned CTR_WIDTH   = 2,
  parameter int unsigned GHR_BITS    = 8,
  parameter int unsigned MODE        = 1,
  parameter int unsigned PERF_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           fetch_pc,
  output logic                  pred_taken,
  output logic [31:0]           pred_target,
  input  logic                  upd_valid,
  input  logic                  upd_stall,
  input  logic [31:0]           upd_pc,
  input  logic                  upd_is_jump,
  input  logic                  upd_taken,
  input  logic [31:0]           upd_target,
  input  logic                  upd_pred_taken,
  input  logic [31:0]           upd_pred_target,
  output logic                  upd_mispredict,
  output logic [PERF_WIDTH-1:0] perf_branches,
  output logic [PERF_WIDTH-1:0] perf_mispredicts
);

  localparam int unsigned BI_W   = $clog2(BTB_ENTRIES);
  localparam int unsigned PI_W   = $clog2(PHT_ENTRIES);
  localparam bp_mode_e    P_MODE = (MODE == 0) ? BP_BIMODAL : BP_GSHARE;

  bp_btb_entry_t         r_btb [BTB_ENTRIES];
  logic [GHR_BITS-1:0]   r_ghr;
  logic [PERF_WIDTH-1:0] r_perf_br;
  logic [PERF_WIDTH-1:0] r_perf_mis;

  bp_upd_t               w_upd;
  logic [BI_W-1:0]       w_fbi;
  bp_btb_entry_t         w_fent;
  logic                  w_fhit;
  logic [PI_W-1:0]       w_fpi;
  logic [CTR_WIDTH-1:0]  w_fctr;
  logic [BI_W-1:0]       w_ubi;
  bp_btb_entry_t         w_uent;
  logic                  w_uhit;
  logic [PI_W-1:0]       w_upi;
  logic [31:0]           w_actual_npc;
  logic                  w_commit;
  logic                  w_ctr_we;
  bp_ctr_op_e            w_ctr_op;

  function automatic logic [PI_W-1:0] pht_index(input logic [31:0] pc, input logic [GHR_BITS-1:0] ghr);
    logic [PI_W-1:0] base;
    base = pc[PI_W+1:2];
    if (P_MODE == BP_GSHARE) begin
      return base ^ PI_W'(ghr);
    end
    return base;
  endfunction

  assign w_upd = '{valid:       upd_valid,
                   stall:       upd_stall,
                   pc:          upd_pc,
                   is_jump:     upd_is_jump,
                   taken:       upd_taken,
                   target:      upd_target,
                   pred_taken:  upd_pred_taken,
                   pred_target: upd_pred_target};

  // Lookup path: purely combinational from registered state.
  assign w_fbi       = fetch_pc[BI_W+1:2];
  assign w_fent      = r_btb[w_fbi];
  assign w_fhit      = w_fent.valid && (w_fent.tag == bp_tag(fetch_pc, BI_W));
  assign w_fpi       = pht_index(fetch_pc, r_ghr);
  assign pred_taken  = w_fhit && (w_fent.jump || w_fctr[CTR_WIDTH-1]);
  assign pred_target = pred_taken ? w_fent.target : bp_seq_pc(fetch_pc);

  assign w_ubi          = w_upd.pc[BI_W+1:2];
  assign w_uent         = r_btb[w_ubi];
  assign w_uhit         = w_uent.valid && (w_uent.tag == bp_tag(w_upd.pc, BI_W));
  assign w_upi          = pht_index(w_upd.pc, r_ghr);
  assign w_actual_npc   = w_upd.taken ? w_upd.target : bp_seq_pc(w_upd.pc);
  assign upd_mispredict = w_upd.valid && (w_actual_npc != w_upd.pred_target);
  assign w_commit       = w_upd.valid && !w_upd.stall;

  // A taken branch that allocates a BTB entry starts its counter at weakly-taken.
  assign w_ctr_we = w_commit && !w_upd.is_jump;
  always_comb begin
    w_ctr_op = BP_CTR_DEC;
    if (w_upd.taken) begin
      w_ctr_op = w_uhit ? BP_CTR_INC : BP_CTR_SET_WT;
    end
  end

  bp_sat_ctr_table #(
    .ENTRIES (PHT_ENTRIES),
    .WIDTH   (CTR_WIDTH)
  ) u_pht (
    .clk      (clk),
    .rst      (rst),
    .i_rd_idx (w_fpi),
    .o_rd_ctr (w_fctr),
    .i_wr_en  (w_ctr_we),
    .i_wr_idx (w_upi),
    .i_wr_op  (w_ctr_op)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        r_btb[i] <= '0;
      end
    end else if (w_commit && w_upd.taken) begin
      r_btb[w_ubi] <= '{valid:  1'b1,
                        tag:    bp_tag(w_upd.pc, BI_W),
                        target: w_upd.target,
                        jump:   w_upd.is_jump};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (w_commit && !w_upd.is_jump) begin
      r_ghr <= (r_ghr << 1) | GHR_BITS'(w_upd.taken);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_br  <= '0;
      r_perf_mis <= '0;
    end else if (w_commit) begin
      if (r_perf_br != '1) begin
        r_perf_br <= r_perf_br + PERF_WIDTH'(1);
      end
      if (upd_mispredict && (r_perf_mis != '1)) begin
        r_perf_mis <= r_perf_mis + PERF_WIDTH'(1);
      end
    end
  end

  assign perf_branches    = r_perf_br;
  assign perf_mispredicts = r_perf_mis;

endmodule
